// File: rtl/inst_fetch.sv
// Purpose: program counter and fetch sequencer ahead of the instruction ROM, with Start/Ack run handshake and retired count.
// Latency: ProgCtr and InstCount update one cycle after controls are sampled; branches redirect the very next fetch.
// Backpressure: Stall freezes ProgCtr and InstCount; a halt on the same cycle still retires.
module inst_fetch #(
  parameter int A  = 10,
  parameter int OW = 6,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchAbs,
  input  logic          BranchRel,
  input  logic [A-1:0]  Target,
  input  logic [OW-1:0] Offset,
  output logic [A-1:0]  ProgCtr,
  output logic          Running,
  output logic          Ack,
  output logic [CW-1:0] InstCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t        r_state;
  logic [A-1:0]  r_pc;
  logic [CW-1:0] r_cnt;
  logic          r_running;
  logic          r_ack;

  logic [A-1:0]  w_off_sext;
  logic [A-1:0]  w_pc_rel;
  logic [A-1:0]  w_pc_inc;
  logic [A-1:0]  w_pc_next;
  logic [CW-1:0] w_cnt_inc;

  // Offset is two's complement; widening keeps the sign so PC + offset wraps modulo 2^A.
  assign w_off_sext = {{(A-OW){Offset[OW-1]}}, Offset};
  assign w_pc_rel   = r_pc + w_off_sext;
  assign w_pc_inc   = r_pc + A'(1);
  // Retired count sticks at all-ones instead of wrapping.
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

  // Next fetch address for an un-stalled, non-halting RUN cycle: absolute beats relative beats sequential.
  always_comb begin
    w_pc_next = w_pc_inc;
    if (BranchAbs) begin
      w_pc_next = Target;
    end else if (BranchRel) begin
      w_pc_next = w_pc_rel;
    end
  end

  // Run-control FSM; PC, count and handshake outputs are all registered alongside the state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_ARMED;
            r_pc    <= StartAddr;
            r_cnt   <= '0;
          end
        end
        S_ARMED: begin
          if (Start) begin
            // Keep following StartAddr until Start drops.
            r_pc <= StartAddr;
          end else begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (Start) begin
            // Restart wins over every fetch control.
            r_state   <= S_ARMED;
            r_pc      <= StartAddr;
            r_cnt     <= '0;
            r_running <= 1'b0;
          end else if (Halt) begin
            r_state   <= S_HALTED;
            r_cnt     <= w_cnt_inc;
            r_running <= 1'b0;
            r_ack     <= 1'b1;
          end else if (!Stall) begin
            r_pc  <= w_pc_next;
            r_cnt <= w_cnt_inc;
          end
        end
        S_HALTED: begin
          if (Start) begin
            r_state <= S_ARMED;
            r_pc    <= StartAddr;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_ack     <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr   = r_pc;
  assign Running   = r_running;
  assign Ack       = r_ack;
  assign InstCount = r_cnt;

endmodule
